oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'hFF46, the CPU address of the DMA source register.
REQ-002 SHALL have parameter OAM_LEN, default 160, the number of bytes per transfer.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port cpu_addr, input, 16, the CPU bus address.
REQ-006 SHALL have port cpu_data_w, input, 8, the CPU write data.
REQ-007 SHALL have port cpu_do_write, input, 1, the CPU write strobe.
REQ-008 SHALL have port cpu_data_r, output, 8, the read data returned to the CPU.
REQ-009 SHALL have port mem_data_r, input, 8, the top-level read-mux result for bus_addr.
REQ-010 SHALL have port bus_addr, output, 16, the shared memory bus address.
REQ-011 SHALL have port bus_do_write, output, 1, the shared bus write strobe.
REQ-012 SHALL have port oam_addr, output, 8, the dedicated OAM write-port index.
REQ-013 SHALL have port oam_data_w, output, 8, the OAM write data.
REQ-014 SHALL have port oam_do_write, output, 1, the OAM write strobe.
REQ-015 SHALL have port dma_active, output, 1, high while the DMA owns the bus.

Function
REQ-016 SHALL run a state machine with states IDLE, START, READ and WRITE.
REQ-017 SHALL, on a clk edge with cpu_do_write=1 and cpu_addr==DMA_REG_ADDR, latch src_hi=cpu_data_w, clear idx to 0 and enter START from any state (a write during an active transfer restarts it).
REQ-018 SHALL go START->READ after one cycle; dma_active=1 in READ and WRITE only.
REQ-019 SHALL in READ drive bus_addr={eff_hi,idx}, where eff_hi=src_hi-8'h20 if src_hi>=8'hE0 (echo mirror) and eff_hi=src_hi otherwise.
REQ-020 SHALL in WRITE hold the same bus_addr, drive oam_addr=idx, oam_data_w=mem_data_r and oam_do_write=1.
REQ-021 SHALL go WRITE->READ with idx+1 while idx<OAM_LEN-1, otherwise WRITE->IDLE; a transfer is 1+2*OAM_LEN=321 cycles from the register write.
REQ-022 SHALL drive bus_addr=cpu_addr and bus_do_write=cpu_do_write in IDLE and START, and bus_do_write=0 in READ and WRITE (CPU writes to non-HRAM addresses are dropped).
REQ-023 SHALL keep oam_do_write=0 outside WRITE.
REQ-024 SHALL return cpu_data_r=src_hi when cpu_addr==DMA_REG_ADDR, in any state.
REQ-025 SHALL return cpu_data_r=mem_data_r when dma_active=0 and cpu_addr is not DMA_REG_ADDR.
REQ-026 SHALL return cpu_data_r=8'hFF when dma_active=1 and cpu_addr is outside FF80-FFFE and is not DMA_REG_ADDR; HRAM reads while active are served by the top level from cpu_addr directly.
REQ-027 SHALL treat an idx value outside 0..OAM_LEN-1 as unreachable; idx is 8 bits wide.

Reset
REQ-028 SHALL on reset, without waiting for clk, enter IDLE with src_hi=8'h00, idx=0, dma_active=0, oam_do_write=0, oam_addr=0 and oam_data_w=0; bus_addr and bus_do_write then follow the CPU port.
REQ-029 SHALL abort a transfer on reset mid-operation, leave OAM bytes already written unchanged and perform no further OAM writes.

Structure
REQ-030 SHALL take OAM_BASE, OAM_SIZE, HRAM_BASE, HRAM_SIZE, DMA_REG_ADDR and the state encoding from a shared memory-map include file used by the top level.
REQ-031 SHALL be a single module with no sub-module; the top level wires bus_addr and bus_do_write into every bus memory and wires oam_* to the OAM write port.

Verification
REQ-032 SHALL cover a basic transfer: preload C000-C09F with i^8'h5A, write 8'hC0 to FF46 -> OAM[i]==i^8'h5A for all i, dma_active high for exactly 320 cycles starting 1 cycle after the write.
REQ-033 SHALL cover the echo source: write 8'hFE to FF46 -> bus_addr runs DE00..DE9F.
REQ-034 SHALL cover CPU blocking: during DMA, read C123 -> 8'hFF; read FF46 -> 8'hC0; read FF90 -> HRAM value; write to C000 -> memory unchanged.
REQ-035 SHALL cover restart: write 8'hC1 to FF46 at idx 50 -> idx resets to 0, source C100, completion 321 cycles after the second write.
REQ-036 SHALL cover reset mid-transfer: assert reset at idx 80 -> dma_active=0 immediately, OAM[80..159] unchanged, bus_addr==cpu_addr.
REQ-037 SHALL cover the idle pass-through: CPU write of 8'h77 to 8000 -> bus_do_write=1, bus_addr=8000, oam_do_write=0.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// Shared memory-map constants and the OAM DMA state encoding.
// The top level and the DMA engine both import this package so that
// address decoding stays consistent across the bus.
package oam_dma_pkg;

  localparam logic [15:0] OAM_BASE             = 16'hFE00;
  localparam int          OAM_SIZE             = 160;
  localparam logic [15:0] HRAM_BASE            = 16'hFF80;
  localparam int          HRAM_SIZE            = 127;
  localparam logic [15:0] HRAM_LAST            = 16'hFFFE;
  localparam logic [15:0] DMA_REG_ADDR_DEFAULT = 16'hFF46;
  localparam int          OAM_LEN_DEFAULT      = 160;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } dma_state_e;

  // Source pages E0-FF alias work RAM through the echo mirror.
  function automatic logic [7:0] echo_fold(input logic [7:0] hi);
    return (hi >= 8'hE0) ? (hi - 8'h20) : hi;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine.
// A CPU write to DMA_REG_ADDR latches the source page and copies OAM_LEN
// bytes from {page,idx} on the shared bus into OAM, one READ and one WRITE
// cycle per byte. While the copy runs the CPU is cut off from the bus:
// its writes are dropped and its reads return 8'hFF (HRAM excepted, which
// the top level serves directly).
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   cpu_addr/_data_w   CPU bus address, write data, write strobe
//   cpu_do_write
//   cpu_data_r         read data returned to the CPU
//   mem_data_r         top-level read-mux result for bus_addr
//   bus_addr,          shared memory bus address / write strobe
//   bus_do_write
//   oam_addr/_data_w/  dedicated OAM write port
//   oam_do_write
//   dma_active         DMA owns the bus (READ and WRITE states)
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT,
  parameter int          OAM_LEN      = OAM_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_w,
  input  logic        cpu_do_write,
  output logic [7:0]  cpu_data_r,
  input  logic [7:0]  mem_data_r,
  output logic [15:0] bus_addr,
  output logic        bus_do_write,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data_w,
  output logic        oam_do_write,
  output logic        dma_active
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

  dma_state_e state_q, state_d;
  logic [7:0] src_hi_q, src_hi_d;
  logic [7:0] idx_q, idx_d;
  logic       reg_wr;
  logic       cpu_in_hram;
  logic [15:0] dma_addr;

  assign reg_wr      = cpu_do_write && (cpu_addr == DMA_REG_ADDR);
  assign cpu_in_hram = (cpu_addr >= HRAM_BASE) && (cpu_addr <= HRAM_LAST);
  assign dma_addr    = {echo_fold(src_hi_q), idx_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      src_hi_q <= 8'h00;
      idx_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      src_hi_q <= src_hi_d;
      idx_q    <= idx_d;
    end
  end

  // Next state: a register write restarts the copy from any state.
  always_comb begin
    state_d  = state_q;
    src_hi_d = src_hi_q;
    idx_d    = idx_q;
    if (reg_wr) begin
      state_d  = ST_START;
      src_hi_d = cpu_data_w;
      idx_d    = 8'h00;
    end else begin
      case (state_q)
        ST_START: state_d = ST_READ;
        ST_READ:  state_d = ST_WRITE;
        ST_WRITE: begin
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_READ;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_addr     = cpu_addr;
    bus_do_write = cpu_do_write;
    oam_addr     = 8'h00;
    oam_data_w   = 8'h00;
    oam_do_write = 1'b0;
    dma_active   = 1'b0;
    case (state_q)
      ST_READ: begin
        bus_addr     = dma_addr;
        bus_do_write = 1'b0;
        dma_active   = 1'b1;
      end
      ST_WRITE: begin
        bus_addr     = dma_addr;
        bus_do_write = 1'b0;
        dma_active   = 1'b1;
        oam_addr     = idx_q;
        oam_data_w   = mem_data_r;
        oam_do_write = 1'b1;
      end
      default: ;
    endcase
  end

  // HRAM reads during DMA are answered by the top level from cpu_addr;
  // the value returned here for that case is not used.
  always_comb begin
    if (cpu_addr == DMA_REG_ADDR)
      cpu_data_r = src_hi_q;
    else if (!dma_active)
      cpu_data_r = mem_data_r;
    else if (cpu_in_hram)
      cpu_data_r = mem_data_r;
    else
      cpu_data_r = 8'hFF;
  end

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_w;
  logic        cpu_do_write;
  logic [7:0]  cpu_data_r;
  logic [7:0]  mem_data_r;
  logic [15:0] bus_addr;
  logic        bus_do_write;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data_w;
  logic        oam_do_write;
  logic        dma_active;

  logic [7:0]  mem [65536];
  logic [7:0]  oam [256];
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  oam_dma dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_data_w   (cpu_data_w),
    .cpu_do_write (cpu_do_write),
    .cpu_data_r   (cpu_data_r),
    .mem_data_r   (mem_data_r),
    .bus_addr     (bus_addr),
    .bus_do_write (bus_do_write),
    .oam_addr     (oam_addr),
    .oam_data_w   (oam_data_w),
    .oam_do_write (oam_do_write),
    .dma_active   (dma_active)
  );

  // Top-level model: bus memory, OAM port, and the HRAM read bypass.
  assign mem_data_r = mem[bus_addr];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus_do_write) mem[bus_addr] <= cpu_data_w;
    if (oam_do_write) oam[oam_addr] <= oam_data_w;
  end

  function automatic logic [7:0] cpu_view();
    if (dma_active && cpu_addr >= 16'hFF80 && cpu_addr <= 16'hFFFE)
      return mem[cpu_addr];
    return cpu_data_r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [15:0] base, input int kind);
    for (int i = 0; i < 160; i++) begin
      pre_addr = base + 16'(i);
      pre_data = (kind == 0) ? (8'(i) ^ 8'h5A) : (8'(i) + 8'h11);
      pre_we   = 1'b1;
      @(negedge clk);
    end
    pre_we = 1'b0;
  endtask

  // Called at a negedge; the write lands on the next rising edge.
  task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
    cpu_addr     = a;
    cpu_data_w   = d;
    cpu_do_write = 1'b1;
    @(negedge clk);
    cpu_do_write = 1'b0;
    cpu_addr     = 16'h0000;
  endtask

  task automatic measure(output int first, output int last, output logic [15:0] first_addr);
    first = -1;
    last  = -1;
    first_addr = 16'h0000;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (dma_active) begin
        if (first < 0) begin
          first      = c;
          first_addr = bus_addr;
        end
        last = c;
      end
    end
  endtask

  task automatic wait_idx(input logic [7:0] idx);
    bit ok = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (oam_do_write && oam_addr == idx) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("wait_idx_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (!dma_active) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("wait_idle_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_oam(input string tag, input int split);
    int bad = 0;
    for (int i = 0; i < 160; i++) begin
      logic [7:0] e;
      e = (i < split) ? (8'(i) ^ 8'h5A) : (8'(i) + 8'h11);
      if (oam[i] !== e) bad++;
    end
    check(tag, 32'(bad), 0);
  endtask

  initial begin
    int first, last, k, bad;
    logic [15:0] faddr, lastaddr;

    reset = 1'b1;
    cpu_addr = 16'h0000;
    cpu_data_w = 8'h00;
    cpu_do_write = 1'b0;
    pre_we = 1'b0;
    pre_addr = 16'h0000;
    pre_data = 8'h00;
    repeat (2) @(negedge clk);

    // Reset state
    cpu_addr = 16'hFF46;
    #1;
    check("rst_active", 32'(dma_active), 0);
    check("rst_oam_we", 32'(oam_do_write), 0);
    check("rst_oam_addr", 32'(oam_addr), 0);
    check("rst_oam_data", 32'(oam_data_w), 0);
    check("rst_src_hi", 32'(cpu_data_r), 8'h00);
    check("rst_bus_addr", 32'(bus_addr), 16'hFF46);
    reset = 1'b0;
    cpu_addr = 16'h0000;
    @(negedge clk);

    preload(16'hC000, 0);
    preload(16'hC100, 1);
    pre_addr = 16'hFF90; pre_data = 8'h3C; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;

    // Idle read pass-through
    cpu_addr = 16'hC005;
    #1 check("idle_read", 32'(cpu_data_r), 8'h5F);
    cpu_addr = 16'h0000;

    // Basic transfer
    write_reg(16'hFF46, 8'hC0);
    check("start_not_active", 32'(dma_active), 0);
    measure(first, last, faddr);
    check("basic_first", 32'(first), 1);
    check("basic_last", 32'(last), 320);
    check("basic_first_addr", 32'(faddr), 16'hC000);
    check_oam("basic_oam", 160);

    // Echo source
    write_reg(16'hFF46, 8'hFE);
    k = 0; bad = 0; lastaddr = 16'h0000;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (dma_active && !oam_do_write) begin
        if (bus_addr !== 16'hDE00 + 16'(k)) bad++;
        lastaddr = bus_addr;
        k++;
      end
    end
    check("echo_reads", 32'(k), 160);
    check("echo_addr_bad", 32'(bad), 0);
    check("echo_last_addr", 32'(lastaddr), 16'hDE9F);

    // CPU blocking during DMA
    write_reg(16'hFF46, 8'hC0);
    repeat (3) @(negedge clk);
    cpu_addr = 16'hC123;
    #1 check("blk_read_wram", 32'(cpu_data_r), 8'hFF);
    cpu_addr = 16'hFF46;
    #1 check("blk_read_reg", 32'(cpu_data_r), 8'hC0);
    cpu_addr = 16'hFF90;
    #1 check("blk_read_hram", 32'(cpu_view()), 8'h3C);
    check("blk_active", 32'(dma_active), 1);
    cpu_addr = 16'hC000;
    cpu_data_w = 8'h99;
    cpu_do_write = 1'b1;
    #1 check("blk_bus_we", 32'(bus_do_write), 0);
    @(negedge clk);
    cpu_do_write = 1'b0;
    cpu_addr = 16'h0000;
    wait_idle();
    check("blk_mem_kept", 32'(mem[16'hC000]), 8'h5A);
    check_oam("blk_oam", 160);

    // Restart at idx 50
    write_reg(16'hFF46, 8'hC0);
    wait_idx(8'd50);
    write_reg(16'hFF46, 8'hC1);
    check("rst_start_idle", 32'(dma_active), 0);
    measure(first, last, faddr);
    check("restart_first", 32'(first), 1);
    check("restart_last", 32'(last), 320);
    check("restart_first_addr", 32'(faddr), 16'hC100);
    check_oam("restart_oam", 0);

    // Reset mid-transfer at idx 80
    write_reg(16'hFF46, 8'hC0);
    wait_idx(8'd80);
    cpu_addr = 16'h1234;
    reset = 1'b1;
    #1;
    check("mid_rst_active", 32'(dma_active), 0);
    check("mid_rst_oam_we", 32'(oam_do_write), 0);
    check("mid_rst_bus_addr", 32'(bus_addr), 16'h1234);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cpu_addr = 16'hFF46;
    #1 check("mid_rst_src_hi", 32'(cpu_data_r), 8'h00);
    cpu_addr = 16'h0000;
    repeat (20) @(negedge clk);
    check("mid_rst_still_idle", 32'(dma_active), 0);
    check_oam("mid_rst_oam", 80);

    // Idle pass-through write
    cpu_addr = 16'h8000;
    cpu_data_w = 8'h77;
    cpu_do_write = 1'b1;
    #1;
    check("pass_bus_we", 32'(bus_do_write), 1);
    check("pass_bus_addr", 32'(bus_addr), 16'h8000);
    check("pass_oam_we", 32'(oam_do_write), 0);
    @(negedge clk);
    cpu_do_write = 1'b0;
    cpu_addr = 16'h0000;
    check("pass_mem", 32'(mem[16'h8000]), 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
